// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one multi-cycle ALU between two requesters.
// Optional WAIT-state abort is enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ack,
    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ack,
    output logic [7:0]  alu_operand_a,
    output logic [7:0]  alu_operand_b,
    output logic [1:0]  alu_operation,
    output logic        alu_start,
    input  logic [15:0] alu_result,
    input  logic        alu_ready,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [15:0] resp_result,
    output logic        resp_overflow,
    output logic        resp_zero,
    output logic        resp_error,
    output logic        busy
);
    localparam int unsigned OP_W  = 2;
    localparam int unsigned DAT_W = 8;
    localparam int unsigned RES_W = 16;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic               id_q, id_d;
    logic               grant_id;
    logic [OP_W-1:0]    op_q, op_d;
    logic [DAT_W-1:0]   a_q, a_d, b_q, b_d;
    logic               ack0_q, ack0_d, ack1_q, ack1_d;
    logic               start_q, start_d;
    logic               rvalid_q, rvalid_d;
    logic               rid_q, rid_d;
    logic [RES_W-1:0]   rres_q, rres_d;
    logic               rovf_q, rovf_d, rzero_q, rzero_d;
    logic               busy_q, busy_d;
`ifdef ALU_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rerr_q, rerr_d;
`endif

    // Both pending: the one not served last wins; otherwise the lone requester.
    assign grant_id = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        start_d  = 1'b0;
        rvalid_d = 1'b0;
        rid_d    = rid_q;
        rres_d   = rres_q;
        rovf_d   = rovf_q;
        rzero_d  = rzero_q;
`ifdef ALU_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        rerr_d   = rerr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d = S_ISSUE;
                    id_d    = grant_id;
                    last_d  = grant_id;
                    op_d    = grant_id ? req1_op : req0_op;
                    a_d     = grant_id ? req1_a  : req0_a;
                    b_d     = grant_id ? req1_b  : req0_b;
                    ack0_d  = ~grant_id;
                    ack1_d  = grant_id;
                    start_d = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (alu_ready) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    rid_d    = id_q;
                    rres_d   = alu_result;
                    rovf_d   = alu_overflow;
                    rzero_d  = alu_zero;
`ifdef ALU_ARB_TIMEOUT_EN
                    rerr_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    rid_d    = id_q;
                    rres_d   = '0;
                    rovf_d   = 1'b0;
                    rzero_d  = 1'b0;
                    rerr_d   = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            start_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rid_q    <= 1'b0;
            rres_q   <= '0;
            rovf_q   <= 1'b0;
            rzero_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            rerr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            start_q  <= start_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rres_q   <= rres_d;
            rovf_q   <= rovf_d;
            rzero_q  <= rzero_d;
            busy_q   <= busy_d;
`ifdef ALU_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            rerr_q   <= rerr_d;
`endif
        end
    end

    assign req0_ack      = ack0_q;
    assign req1_ack      = ack1_q;
    assign alu_operand_a = a_q;
    assign alu_operand_b = b_q;
    assign alu_operation = op_q;
    assign alu_start     = start_q;
    assign resp_valid    = rvalid_q;
    assign resp_id       = rid_q;
    assign resp_result   = rres_q;
    assign resp_overflow = rovf_q;
    assign resp_zero     = rzero_q;
    assign busy          = busy_q;
`ifdef ALU_ARB_TIMEOUT_EN
    assign resp_error    = rerr_q;
`else
    assign resp_error    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus random two-requester traffic.
// Honours ALU_ARB_TIMEOUT_EN the same way as the design.
module tb_alu_arbiter;
    localparam int unsigned TMO = 64;

    logic clk = 1'b0;
    logic reset;
    logic req0_valid, req1_valid, req0_ack, req1_ack;
    logic [1:0] req0_op, req1_op, alu_operation;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_operand_a, alu_operand_b;
    logic alu_start, alu_ready, alu_overflow, alu_zero;
    logic [15:0] alu_result, resp_result;
    logic resp_valid, resp_id, resp_overflow, resp_zero, resp_error, busy;

    always #5 clk = ~clk;

    alu_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ack(req0_ack),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ack(req1_ack),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_operation(alu_operation),
        .alu_start(alu_start), .alu_result(alu_result), .alu_ready(alu_ready),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
        .resp_overflow(resp_overflow), .resp_zero(resp_zero), .resp_error(resp_error), .busy(busy)
    );

    typedef struct {
        logic        id;
        logic [15:0] res;
        logic        ovf;
        logic        zero;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_chk = 0, n_pass = 0, cyc = 0, n_resp = 0, n_start = 0;
    logic last_srv;
    logic [1:0] rop[2];
    logic [7:0] ra[2], rb[2];
    bit   alu_pending = 0, alu_hang = 0, force_ovf = 0;
    int   alu_cnt = 0, force_delay = -1;
    logic [1:0] cap_op;
    logic [7:0] cap_a, cap_b;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference ALU: {overflow, result}
    function automatic logic [16:0] alu_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        logic v;
        case (op)
            2'd0: begin r = 16'(a) + 16'(b); v = (r > 16'd255); end
            2'd1: begin r = 16'(a) - 16'(b); v = (b > a); end
            2'd2: begin r = 16'(a) * 16'(b); v = 1'b0; end
            default: begin
                if (b == 8'd0) begin r = 16'hFFFF; v = 1'b1; end
                else begin r = 16'(a / b); v = 1'b0; end
            end
        endcase
        return {v, r};
    endfunction

    function automatic logic [63:0] outs();
        return 64'({req0_ack, req1_ack, alu_operand_a, alu_operand_b, alu_operation, alu_start,
                    resp_valid, resp_id, resp_result, resp_overflow, resp_zero, resp_error, busy});
    endfunction

    task automatic raise(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        rop[i] = op; ra[i] = a; rb[i] = b;
        if (i == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        else        begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    endtask

    // One clock: grant tracking, expected-response push, ALU environment model.
    task automatic tick();
        int w, ew, d;
        exp_t e;
        logic [16:0] m;
        @(posedge clk);
        cyc++;
        #1;
        alu_ready    = 1'b0;
        alu_result   = 16'($urandom);
        alu_overflow = 1'($urandom);
        alu_zero     = 1'($urandom);
        if (alu_start) n_start++;
        if (req0_ack || req1_ack) begin
            chk("ack_both", 64'(req0_ack & req1_ack), 64'(0));
            w  = req1_ack ? 1 : 0;
            ew = (req0_valid && req1_valid) ? (last_srv ? 0 : 1) : (req1_valid ? 1 : 0);
            chk("grant_had_req", 64'(w == 1 ? req1_valid : req0_valid), 64'(1));
            chk("rr_winner", 64'(w), 64'(ew));
            last_srv = 1'(w);
            grant_log.push_back(w);
            chk("start_with_ack", 64'(alu_start), 64'(1));
            d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
            m = alu_model(rop[w], ra[w], rb[w]);
            e.id = 1'(w); e.res = m[15:0]; e.ovf = m[16] | force_ovf; e.zero = (m[15:0] == 16'd0);
            e.err = 1'b0; e.cyc = cyc + 2 + d;
            if (alu_hang) begin
`ifdef ALU_ARB_TIMEOUT_EN
                e.res = '0; e.ovf = 1'b0; e.zero = 1'b0; e.err = 1'b1; e.cyc = cyc + 1 + int'(TMO);
`else
                e.cyc = -1;
`endif
            end
            sb.push_back(e);
            alu_cnt = d;
            if (w == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
        end else if (alu_start) begin
            chk("stray_start", 64'(alu_start), 64'(0));
        end
        if (alu_start) begin
            alu_pending = 1'b1;
            cap_op = alu_operation; cap_a = alu_operand_a; cap_b = alu_operand_b;
        end else if (alu_pending && !alu_hang) begin
            chk("opnd_stable", 64'({alu_operation, alu_operand_a, alu_operand_b}), 64'({cap_op, cap_a, cap_b}));
            if (alu_cnt == 0) begin
                m = alu_model(cap_op, cap_a, cap_b);
                alu_result = m[15:0]; alu_overflow = m[16] | force_ovf; alu_zero = (m[15:0] == 16'd0);
                alu_ready = 1'b1; alu_pending = 1'b0;
            end else begin
                alu_cnt--;
            end
        end
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while ((sb.size() != 0 || busy || req0_valid || req1_valid) && b < budget) begin
            tick();
            b++;
        end
        chk("drain_in_time", 64'(b < budget), 64'(1));
    endtask

    // Monitor: pop and compare on every response pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                n_resp++;
                if (sb.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'(0));
                else begin
                    e = sb.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("resp_id", 64'(resp_id), 64'(e.id));
                    chk("resp_result", 64'(resp_result), 64'(e.res));
                    chk("resp_overflow", 64'(resp_overflow), 64'(e.ovf));
                    chk("resp_zero", 64'(resp_zero), 64'(e.zero));
                    chk("resp_error", 64'(resp_error), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, s0;
        reset = 1'b0; last_srv = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        alu_ready = 0; alu_result = 0; alu_overflow = 0; alu_zero = 0;
        raise(0, 2'd0, 8'd20, 8'd22);
        raise(1, 2'd2, 8'd3, 8'd4);
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", outs(), 64'(0));
        @(negedge clk) reset = 1'b1;

        // Both held continuously: grants must alternate starting with req0.
        begin
            int b = 0;
            while (grant_log.size() < 4 && b < 200) begin
                tick();
                b++;
                if (!req0_valid) raise(0, 2'($urandom), 8'($urandom), 8'($urandom));
                if (!req1_valid) raise(1, 2'($urandom), 8'($urandom), 8'($urandom));
            end
        end
        for (int i = 0; i < 4; i++) chk("alternate", 64'(i < grant_log.size() ? grant_log[i] : 9), 64'(i % 2));
        drain(200);

        force_delay = 0;
        raise(0, 2'd0, 8'd5, 8'd3);
        drain(50);
        force_ovf = 1'b1;
        raise(0, 2'd1, 8'd0, 8'd0);
        drain(50);
        force_ovf = 1'b0;
        force_delay = 5;
        s0 = n_start;
        raise(1, 2'd2, 8'd12, 8'd10);
        drain(50);
        chk("single_start", 64'(n_start - s0), 64'(1));
        force_delay = -1;

        alu_hang = 1'b1;
        raise(0, 2'd0, 8'd1, 8'd1);
`ifdef ALU_ARB_TIMEOUT_EN
        repeat (int'(TMO) + 10) tick();
        chk("timeout_resp_seen", 64'(sb.size()), 64'(0));
        alu_pending = 1'b0;
        raise(0, 2'd0, 8'd2, 8'd2);
        repeat (10) tick();
`else
        n0 = n_resp;
        repeat (200) tick();
        chk("no_resp_hang", 64'(n_resp), 64'(n0));
`endif
        chk("busy_in_wait", 64'(busy), 64'(1));
        @(negedge clk);
        reset = 1'b0;
        #1 chk("async_reset", outs(), 64'(0));
        sb.delete(); alu_pending = 1'b0; alu_hang = 1'b0; last_srv = 1'b1;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        chk("reset_held", outs(), 64'(0));
        reset = 1'b1;
        raise(0, 2'd0, 8'd7, 8'd9);
        drain(50);

        // Random traffic with occasional withdrawal before ack.
        repeat (1500) begin
            tick();
            if (!req0_valid && $urandom_range(0, 2) == 0) raise(0, 2'($urandom), 8'($urandom), 8'($urandom));
            else if (req0_valid && $urandom_range(0, 15) == 0) req0_valid = 1'b0;
            if (!req1_valid && $urandom_range(0, 2) == 0) raise(1, 2'($urandom), 8'($urandom), 8'($urandom));
            else if (req1_valid && $urandom_range(0, 15) == 0) req1_valid = 1'b0;
        end
        drain(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
